// File: rtl/rpn_stack_controller.sv
// RPN calculator stack sequencer: keeps TOS in a register, spills the
// lower entries to a sync-read RAM and steps the ALU for binary ops.
module rpn_stack_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] tos,
  output logic [ADDR_W:0]   depth,
  output logic              err_overflow,
  output logic              err_underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_COMMIT
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] C_TWO  = (ADDR_W+1)'(2);

  state_t              r_state;
  logic [DATA_W-1:0]   r_tos;
  logic [ADDR_W:0]     r_depth;
  logic                r_ovf;
  logic                r_unf;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_aluop;
  logic                r_pop;

  state_t              w_state_n;
  logic [DATA_W-1:0]   w_tos_n;
  logic [ADDR_W:0]     w_depth_n;
  logic                w_ovf_n;
  logic                w_unf_n;
  logic [ADDR_W-1:0]   w_addr_n;
  logic [1:0]          w_aluop_n;
  logic                w_pop_n;
  logic                w_we;
  logic [ADDR_W-1:0]   w_maddr;
  logic [ADDR_W-1:0]   w_dm1;
  logic [ADDR_W-1:0]   w_dm2;
  logic                w_accept;

  // RAM slot just below TOS is depth-1 (push) or depth-2 (read of NOS)
  assign w_dm1    = r_depth[ADDR_W-1:0] - ADDR_W'(1);
  assign w_dm2    = r_depth[ADDR_W-1:0] - ADDR_W'(2);
  assign w_accept = cmd_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_n = r_state;
    w_tos_n   = r_tos;
    w_depth_n = r_depth;
    w_ovf_n   = r_ovf;
    w_unf_n   = r_unf;
    w_addr_n  = r_addr;
    w_aluop_n = r_aluop;
    w_pop_n   = r_pop;
    w_we      = 1'b0;
    w_maddr   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (cmd_op)
            OP_PUSH: begin
              if (r_depth == C_FULL) begin
                w_ovf_n = 1'b1;
              end else begin
                if (r_depth != '0) begin
                  w_we    = 1'b1;
                  w_maddr = w_dm1;
                end
                w_tos_n   = cmd_data;
                w_depth_n = r_depth + C_ONE;
              end
            end
            OP_POP: begin
              if (r_depth == '0) begin
                w_unf_n = 1'b1;
              end else if (r_depth == C_ONE) begin
                w_tos_n   = '0;
                w_depth_n = '0;
              end else begin
                w_maddr   = w_dm2;
                w_addr_n  = w_dm2;
                w_pop_n   = 1'b1;
                w_state_n = S_READ;
              end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND: begin
              if (r_depth < C_TWO) begin
                w_unf_n = 1'b1;
              end else begin
                w_maddr   = w_dm2;
                w_addr_n  = w_dm2;
                w_pop_n   = 1'b0;
                // cmd_op-3 modulo 4 for opcodes 3..6
                w_aluop_n = cmd_op[1:0] + 2'd1;
                w_state_n = S_READ;
              end
            end
            OP_CLEAR: begin
              w_tos_n   = '0;
              w_depth_n = '0;
              w_ovf_n   = 1'b0;
              w_unf_n   = 1'b0;
            end
            OP_NOP: begin
              w_state_n = S_IDLE;
            end
            default: begin
              w_state_n = S_IDLE;
            end
          endcase
        end
      end
      S_READ: begin
        w_maddr   = r_addr;
        w_state_n = S_COMMIT;
      end
      S_COMMIT: begin
        w_maddr   = r_addr;
        w_tos_n   = r_pop ? mem_rdata : alu_result;
        w_depth_n = r_depth - C_ONE;
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tos   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_addr  <= '0;
      r_aluop <= '0;
      r_pop   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tos   <= w_tos_n;
      r_depth <= w_depth_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      r_addr  <= w_addr_n;
      r_aluop <= w_aluop_n;
      r_pop   <= w_pop_n;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign mem_we        = w_we;
  assign mem_addr      = w_maddr;
  assign mem_wdata     = r_tos;
  assign alu_a         = mem_rdata;
  assign alu_b         = r_tos;
  assign alu_op        = r_aluop;
  assign tos           = r_tos;
  assign depth         = r_depth;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_unf;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Bench for rpn_stack_controller: directed vector table, corner sequences
// and random commands against a queue-based stack model.
module tb_rpn_stack_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic [7:0] tos;
  logic [3:0] depth;
  logic       err_overflow;
  logic       err_underflow;

  always #5 clk = ~clk;

  rpn_stack_controller #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .tos(tos),
    .depth(depth),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  logic [7:0] ram [0:7];

  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      2'd0: alu_result = alu_a + alu_b;
      2'd1: alu_result = alu_a - alu_b;
      2'd2: alu_result = alu_a * alu_b;
      2'd3: alu_result = alu_a & alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  int total = 0;
  int bad = 0;
  int stk[$];
  int m_ovf = 0;
  int m_unf = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    int tos;
    int dep;
    int ovf;
    int unf;
    int busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int m_tos();
    if (stk.size() == 0) return 0;
    return stk[stk.size()-1];
  endfunction

  task automatic model(input logic [2:0] op, input logic [7:0] d,
                       output int busy, output int we);
    int a;
    int b;
    int r;
    busy = 0;
    we = 0;
    case (op)
      3'd1: begin
        if (stk.size() == 8) m_ovf = 1;
        else begin
          we = (stk.size() > 0) ? 1 : 0;
          stk.push_back(int'(d));
        end
      end
      3'd2: begin
        if (stk.size() == 0) m_unf = 1;
        else begin
          if (stk.size() >= 2) busy = 2;
          void'(stk.pop_back());
        end
      end
      3'd3, 3'd4, 3'd5, 3'd6: begin
        if (stk.size() < 2) m_unf = 1;
        else begin
          b = stk.pop_back();
          a = stk.pop_back();
          case (op)
            3'd3: r = a + b;
            3'd4: r = a - b;
            3'd5: r = a * b;
            default: r = a & b;
          endcase
          stk.push_back(r & 255);
          busy = 2;
        end
      end
      3'd7: begin
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
      end
      default: ;
    endcase
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] d,
                     output int busy);
    int eb;
    int ew;
    int n;
    @(negedge clk);
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    model(op, d, eb, ew);
    #1;
    chk("mem_we", int'(mem_we), ew);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_back", int'(cmd_ready), 1);
    chk("busy", n, eb);
    busy = n;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_tos"}, int'(tos), m_tos());
    chk({tag, "_depth"}, int'(depth), stk.size());
    chk({tag, "_ovf"}, int'(err_overflow), m_ovf);
    chk({tag, "_unf"}, int'(err_underflow), m_unf);
  endtask

  function automatic void add(input logic [2:0] op, input logic [7:0] d,
                              input int t, input int dp, input int ov,
                              input int un, input int bz);
    vec_t v;
    v.op = op; v.d = d; v.tos = t; v.dep = dp;
    v.ovf = ov; v.unf = un; v.busy = bz;
    tbl.push_back(v);
  endfunction

  initial begin
    int bz;
    int n;
    int r;
    logic [2:0] op;

    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'h00;

    add(1, 5, 5, 1, 0, 0, 0);
    add(1, 3, 3, 2, 0, 0, 0);
    add(3, 0, 8, 1, 0, 0, 2);
    add(7, 0, 0, 0, 0, 0, 0);
    add(1, 3, 3, 1, 0, 0, 0);
    add(1, 5, 5, 2, 0, 0, 0);
    add(4, 0, 8'hFE, 1, 0, 0, 2);
    add(2, 0, 0, 0, 0, 0, 0);
    add(1, 20, 20, 1, 0, 0, 0);
    add(1, 20, 20, 2, 0, 0, 0);
    add(5, 0, 8'h90, 1, 0, 0, 2);
    add(7, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 8'(i), i, i, 0, 0, 0);
    add(1, 9, 8, 8, 1, 0, 0);
    for (int i = 7; i >= 1; i--) add(2, 0, i, i, 1, 0, 2);
    add(7, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 1, 0);
    add(1, 4, 4, 1, 0, 1, 0);
    add(3, 0, 4, 1, 0, 1, 0);
    add(0, 0, 4, 1, 0, 1, 0);
    add(7, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_tos_held", int'(tos), 0);
    reset = 1'b0;
    #1;
    chk("rst_tos", int'(tos), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_aluop", int'(alu_op), 0);
    chk("rst_ovf", int'(err_overflow), 0);
    chk("rst_unf", int'(err_underflow), 0);

    foreach (tbl[k]) begin
      run(tbl[k].op, tbl[k].d, bz);
      chk($sformatf("v%0d_tos", k), int'(tos), tbl[k].tos);
      chk($sformatf("v%0d_depth", k), int'(depth), tbl[k].dep);
      chk($sformatf("v%0d_ovf", k), int'(err_overflow), tbl[k].ovf);
      chk($sformatf("v%0d_unf", k), int'(err_underflow), tbl[k].unf);
      chk($sformatf("v%0d_busy", k), bz, tbl[k].busy);
    end

    // reset while an ADD is waiting on the RAM read
    run(1, 1, bz);
    run(1, 2, bz);
    @(negedge clk);
    cmd_op = 3'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("mid_busy", int'(cmd_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tos", int'(tos), 0);
    chk("mid_rst_depth", int'(depth), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_we", int'(mem_we), 0);
    @(negedge clk);
    reset = 1'b0;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    @(posedge clk);
    #1;
    check_model("post_rst");

    // PUSH held across a busy MUL
    run(1, 6, bz);
    run(1, 7, bz);
    @(negedge clk);
    cmd_op = 3'd5;
    cmd_valid = 1'b1;
    model(3'd5, 8'h00, bz, n);
    @(posedge clk);
    #1;
    cmd_op = 3'd1;
    cmd_data = 8'h33;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    chk("hold_wait", n, 2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    model(3'd1, 8'h33, bz, n);
    chk("hold_tos", int'(tos), 8'h33);
    chk("hold_depth", int'(depth), 2);
    run(2, 0, bz);
    chk("hold_pop_tos", int'(tos), 42);
    check_model("hold");

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) op = 3'd1;
      else if (r < 60) op = 3'd2;
      else if (r < 90) op = 3'(3 + $urandom_range(0, 3));
      else if (r < 95) op = 3'd0;
      else op = 3'd7;
      run(op, 8'($urandom_range(0, 255)), bz);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
